// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: shifts one framed word onto tx_serial,
// timed by the shared oversampling baud tick.
module uart_tx_sequencer #(
    parameter int DATA_BITS   = 8,
    parameter int SAMPLE_RATE = 16,
    parameter int PARITY      = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 tick,
    output logic                 start_tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy
);
    localparam int CW = (SAMPLE_RATE > 1) ? $clog2(SAMPLE_RATE) : 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_RATE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam bit HAS_PARITY = (PARITY == 1) || (PARITY == 2);
    localparam bit ODD = (PARITY == 2);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY_BIT = 3'd3,
        STOP       = 3'd4
    } state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [IW-1:0]        idx, idx_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 par, par_next;
    logic                 serial_next, start_next;
    logic                 counted, bit_done;

    // The tick that lands in the realign cycle belongs to the old phase.
    assign counted  = tick && !start_tx && (state != IDLE);
    assign bit_done = counted && (cnt == CNT_LAST);
    assign tx_ready = (state == IDLE);
    assign tx_busy  = !tx_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            tx_serial <= 1'b1;
            start_tx  <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            idx       <= idx_next;
            shreg     <= shreg_next;
            par       <= par_next;
            tx_serial <= serial_next;
            start_tx  <= start_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (tx_valid) state_next = START;
            START:      if (bit_done) state_next = DATA;
            DATA: begin
                if (bit_done && idx == IDX_LAST)
                    state_next = HAS_PARITY ? PARITY_BIT : STOP;
            end
            PARITY_BIT: if (bit_done) state_next = STOP;
            STOP:       if (bit_done) state_next = IDLE;
            default:    state_next = IDLE;
        endcase

        cnt_next   = cnt;
        idx_next   = idx;
        shreg_next = shreg;
        par_next   = par;
        if (state == IDLE) begin
            cnt_next = '0;
            idx_next = '0;
            if (tx_valid) begin
                shreg_next = tx_data;
                par_next   = (^tx_data) ^ ODD;
            end
        end else if (bit_done) begin
            cnt_next = '0;
            if (state == DATA) begin
                idx_next   = idx + 1'b1;
                shreg_next = shreg >> 1;
            end
        end else if (counted) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // Line level is decided from the state being entered so it is registered.
    always_comb begin
        start_next = (state == IDLE) && tx_valid;
        case (state_next)
            START:      serial_next = 1'b0;
            DATA:       serial_next = shreg_next[0];
            PARITY_BIT: serial_next = par;
            default:    serial_next = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: four instances (parity modes 0..3)
// with expected frames queued at stimulus time and checked per bit.
module tb_uart_tx_sequencer;
    localparam int ND = 4;

    typedef struct packed {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic          clock, reset_n, tick;
    logic [7:0]    tx_data;
    logic [ND-1:0] valid, stx, rdy, ser, busy;
    int            checks, errors, ph;
    frame_t        exp_q[$];

    logic [15:0] fst, lst;
    int          wcyc, fcyc, scyc;
    logic        rdy_a, ser_a, coll, tmo;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        uart_tx_sequencer #(
            .DATA_BITS(8),
            .SAMPLE_RATE(16),
            .PARITY(g)
        ) dut (
            .clock(clock),
            .reset_n(reset_n),
            .tick(tick),
            .start_tx(stx[g]),
            .tx_data(tx_data),
            .tx_valid(valid[g]),
            .tx_ready(rdy[g]),
            .tx_serial(ser[g]),
            .tx_busy(busy[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        tick = 1'b0;
        ph = 0;
        forever begin
            @(posedge clock);
            #1;
            tick = (ph == 0);
            ph = (ph + 1) % 4;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic frame_t make_frame(input int mode, input logic [7:0] data);
        frame_t f;
        logic p;
        p = ^data;
        f.bits = '0;
        f.bits[8:1] = data;
        f.n = 9;
        if (mode == 1 || mode == 2) begin
            f.bits[9] = (mode == 2) ? ~p : p;
            f.n = 10;
        end
        f.bits[f.n] = 1'b1;
        f.n = f.n + 1;
        return f;
    endfunction

    task automatic align_tick();
        int g = 0;
        do begin
            @(posedge clock);
            #2;
            g++;
        end while (!tick && g < 10);
    endtask

    task automatic send(input int d, input logic [7:0] data);
        tx_data = data;
        valid[d] = 1'b1;
        exp_q.push_back(make_frame(d, data));
        @(posedge clock);
        #1;
        valid[d] = 1'b0;
    endtask

    // Records line level at the first and last counted tick of each bit.
    task automatic capture(input int d, input int nb);
        int cnt, b;
        fst = '0; lst = '0;
        wcyc = 0; fcyc = 0; scyc = 0;
        coll = 1'b0; tmo = 1'b0; rdy_a = 1'b0; ser_a = 1'b0;
        do begin
            @(negedge clock);
            wcyc++;
        end while (!stx[d] && wcyc < 3000);
        if (!stx[d]) begin
            tmo = 1'b1;
            return;
        end
        cnt = 0;
        b = 0;
        forever begin
            fcyc++;
            if (stx[d]) begin
                scyc++;
                if (tick) coll = 1'b1;
            end else if (tick) begin
                cnt++;
                if (cnt % 16 == 1) fst[b] = ser[d];
                if (cnt % 16 == 0) begin
                    lst[b] = ser[d];
                    b++;
                end
            end
            if (b >= nb || fcyc > 3000) break;
            @(negedge clock);
        end
        tmo = (b < nb);
        @(negedge clock);
        rdy_a = rdy[d];
        ser_a = ser[d];
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        valid = '0;
        tx_data = '0;
        #1 reset_n = 1'b0;
        #2;
        checks++; if (ser !== 4'hF) begin errors++; $display("FAIL reset_serial got %b want 1111", ser); end
        checks++; if (rdy !== 4'hF) begin errors++; $display("FAIL reset_ready got %b want 1111", rdy); end
        checks++; if (busy !== 4'h0) begin errors++; $display("FAIL reset_busy got %b want 0000", busy); end
        checks++; if (stx !== 4'h0) begin errors++; $display("FAIL reset_start got %b want 0000", stx); end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (8) @(negedge clock);
        checks++; if (rdy !== 4'hF || ser !== 4'hF) begin
            errors++; $display("FAIL reset_idle got rdy=%b ser=%b want 1111/1111", rdy, ser);
        end
    endtask

    task automatic test_basic();
        frame_t f;
        align_tick();
        send(0, 8'hA5);
        capture(0, exp_q[0].n);
        f = exp_q.pop_front();
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b want 0", tmo); end
        checks++; if (fst !== f.bits) begin errors++; $display("FAIL basic_first got %b want %b", fst, f.bits); end
        checks++; if (lst !== f.bits) begin errors++; $display("FAIL basic_last got %b want %b", lst, f.bits); end
        checks++; if (scyc !== 1) begin errors++; $display("FAIL basic_start_pulse got %0d want 1", scyc); end
        checks++; if (fcyc !== 640) begin errors++; $display("FAIL basic_frame_clocks got %0d want 640", fcyc); end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", rdy_a); end
        checks++; if (ser_a !== 1'b1) begin errors++; $display("FAIL basic_idle_line got %b want 1", ser_a); end
    endtask

    task automatic test_parity();
        frame_t f;
        for (int d = 1; d < ND; d++) begin
            @(posedge clock);
            #1;
            send(d, 8'h07);
            capture(d, exp_q[0].n);
            f = exp_q.pop_front();
            checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL parity%0d_timeout got %b want 0", d, tmo); end
            checks++; if (fst !== f.bits) begin errors++; $display("FAIL parity%0d_first got %b want %b", d, fst, f.bits); end
            checks++; if (lst !== f.bits) begin errors++; $display("FAIL parity%0d_last got %b want %b", d, lst, f.bits); end
            checks++; if (rdy_a !== 1'b1 || ser_a !== 1'b1) begin
                errors++; $display("FAIL parity%0d_end got rdy=%b ser=%b want 1/1", d, rdy_a, ser_a);
            end
        end
    endtask

    task automatic test_back_to_back();
        frame_t f;
        int n;
        @(posedge clock);
        #1;
        tx_data = 8'h00;
        valid[0] = 1'b1;
        exp_q.push_back(make_frame(0, 8'h00));
        exp_q.push_back(make_frame(0, 8'hFF));
        @(posedge clock);
        #1;
        tx_data = 8'hFF;
        capture(0, exp_q[0].n);
        f = exp_q.pop_front();
        checks++; if (fst !== f.bits || lst !== f.bits || tmo) begin
            errors++; $display("FAIL b2b_first_frame got %b/%b want %b", fst, lst, f.bits);
        end
        fork
            capture(0, exp_q[0].n);
            begin
                @(posedge clock);
                #1;
                valid[0] = 1'b0;
            end
        join
        f = exp_q.pop_front();
        checks++; if (wcyc !== 1) begin errors++; $display("FAIL b2b_gap got %0d want 1", wcyc); end
        checks++; if (fst !== f.bits || lst !== f.bits || tmo) begin
            errors++; $display("FAIL b2b_second_frame got %b/%b want %b", fst, lst, f.bits);
        end
        n = 0;
        repeat (100) begin
            @(negedge clock);
            if (stx[0]) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL b2b_extra_start got %0d want 0", n); end
    endtask

    task automatic test_busy_drop();
        frame_t f;
        int n;
        align_tick();
        send(0, 8'h96);
        fork
            capture(0, exp_q[0].n);
            begin
                repeat (200) @(posedge clock);
                #1;
                tx_data = 8'h3C;
                valid[0] = 1'b1;
                checks++; if (rdy[0] !== 1'b0 || busy[0] !== 1'b1) begin
                    errors++; $display("FAIL drop_ready got rdy=%b busy=%b want 0/1", rdy[0], busy[0]);
                end
                @(posedge clock);
                #1;
                valid[0] = 1'b0;
            end
        join
        f = exp_q.pop_front();
        checks++; if (fst !== f.bits || lst !== f.bits || tmo) begin
            errors++; $display("FAIL drop_frame got %b/%b want %b", fst, lst, f.bits);
        end
        n = 0;
        repeat (700) begin
            @(negedge clock);
            if (stx[0]) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL drop_extra_frame got %0d want 0", n); end
    endtask

    task automatic test_mid_reset();
        frame_t f;
        align_tick();
        send(0, 8'hF0);
        void'(exp_q.pop_back());
        repeat (288) @(negedge clock);
        checks++; if (ser[0] !== 1'b0) begin errors++; $display("FAIL mreset_bit3 got %b want 0", ser[0]); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (ser[0] !== 1'b1 || rdy[0] !== 1'b1) begin
            errors++; $display("FAIL mreset_async got ser=%b rdy=%b want 1/1", ser[0], rdy[0]);
        end
        checks++; if (busy[0] !== 1'b0 || stx[0] !== 1'b0) begin
            errors++; $display("FAIL mreset_flags got busy=%b start=%b want 0/0", busy[0], stx[0]);
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        send(0, 8'h55);
        capture(0, exp_q[0].n);
        f = exp_q.pop_front();
        checks++; if (fst !== f.bits || lst !== f.bits || tmo) begin
            errors++; $display("FAIL mreset_frame got %b/%b want %b", fst, lst, f.bits);
        end
        checks++; if (scyc !== 1 || rdy_a !== 1'b1) begin
            errors++; $display("FAIL mreset_end got start=%0d rdy=%b want 1/1", scyc, rdy_a);
        end
    endtask

    task automatic test_collision();
        frame_t f;
        align_tick();
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        send(0, 8'hA5);
        capture(0, exp_q[0].n);
        f = exp_q.pop_front();
        checks++; if (coll !== 1'b1) begin errors++; $display("FAIL coll_setup got %b want 1", coll); end
        checks++; if (fst !== f.bits || lst !== f.bits || tmo) begin
            errors++; $display("FAIL coll_frame got %b/%b want %b", fst, lst, f.bits);
        end
        checks++; if (fcyc !== 641) begin errors++; $display("FAIL coll_frame_clocks got %0d want 641", fcyc); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_busy_drop();
        test_mid_reset();
        test_collision();
        checks++; if (exp_q.size() !== 0) begin
            errors++; $display("FAIL queue_left got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_sequencer.md
UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..9).
REQ-002 SHALL have parameter SAMPLE_RATE, default 16, baud ticks per bit period.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have port clock  input  1  system clock; all state updates on posedge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port tick  input  1  oversample tick from the shared baud rate generator.
REQ-007 SHALL have port start_tx  output  1  one-cycle pulse that realigns the baud rate generator to frame start.
REQ-008 SHALL have port tx_data  input  DATA_BITS  byte to transmit.
REQ-009 SHALL have port tx_valid  input  1  tx_data is valid.
REQ-010 SHALL have port tx_ready  output  1  sequencer can accept a byte.
REQ-011 SHALL have port tx_serial  output  1  serial line; idle high.
REQ-012 SHALL have port tx_busy  output  1  a frame is in progress.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY_BIT, STOP.
REQ-014 tx_ready SHALL be 1 only in IDLE; tx_busy SHALL equal NOT tx_ready.
REQ-015 Accept: tx_valid=1 and tx_ready=1 at a clock edge SHALL latch tx_data into a shift register and move to START.
REQ-016 tx_valid while not in IDLE SHALL be ignored; tx_data SHALL NOT be sampled.
REQ-017 start_tx SHALL be registered and high only in the first cycle of START, for exactly one cycle per frame.
REQ-018 The tick count SHALL be cleared on entry to each bit, with range 0..SAMPLE_RATE-1.
REQ-019 A tick coinciding with start_tx=1 SHALL NOT be counted.
REQ-020 Each bit SHALL last exactly SAMPLE_RATE counted ticks.
REQ-021 The state SHALL advance on the clock edge at which the SAMPLE_RATE-th counted tick of the bit is sampled.
REQ-022 tx_serial SHALL be registered: 0 in START, data bits LSB first in DATA, parity bit in PARITY_BIT, 1 in STOP and IDLE.
REQ-023 DATA SHALL use a bit index 0..DATA_BITS-1. After bit DATA_BITS-1 it SHALL go to PARITY_BIT if PARITY!=0, otherwise to STOP.
REQ-024 The parity bit SHALL be the XOR of the latched data bits for even mode, and its inverse for odd mode.
REQ-025 PARITY_BIT SHALL last SAMPLE_RATE ticks and then go to STOP.
REQ-026 STOP SHALL last SAMPLE_RATE ticks and then go to IDLE, with tx_ready=1 in the following cycle.
REQ-027 Back-to-back frames: a byte SHALL be accepted on the earliest edge where tx_ready=1, with no extra idle bit inserted.
REQ-028 Ticks in IDLE SHALL be ignored.
REQ-029 Counters SHALL NOT wrap mid-bit.
REQ-030 Unused or illegal state encodings SHALL return to IDLE on the next edge.
REQ-031 PARITY values other than 0, 1, 2 SHALL be treated as 0.

Reset
REQ-032 On reset_n=0 the block SHALL go to IDLE immediately, independent of clock: tx_serial=1, tx_ready=1, tx_busy=0, start_tx=0, counters 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with no residual output. The first frame after deassertion SHALL be a complete fresh frame.
REQ-034 State SHALL first change at the first posedge after reset_n deasserts.

Verification
REQ-035 Bench SHALL cover basic frame: tick every 4 clocks, SAMPLE_RATE=16, tx_data=8'hA5, one-cycle valid -> one start_tx pulse; tx_serial = 0,1,0,1,0,0,1,0,1,1; each bit 64 clocks; tx_ready returns after 640 clocks.
REQ-036 Bench SHALL cover even parity: PARITY=1, tx_data=8'h07 -> parity bit 1, frame 11 bits. PARITY=2 -> parity bit 0.
REQ-037 Bench SHALL cover back-to-back: valid held high with 8'h00 then 8'hFF -> second start bit immediately follows first stop bit; exactly two start_tx pulses.
REQ-038 Bench SHALL cover busy drop: tx_valid pulsed with 8'h3C during DATA -> ignored; tx_serial still carries first byte; no extra frame.
REQ-039 Bench SHALL cover mid-frame reset: reset_n low during data bit 3 -> tx_serial=1 and tx_ready=1 with no clock edge. After release, 8'h55 is sent as a complete frame.
REQ-040 Bench SHALL cover tick collision: tick asserted in the start_tx cycle -> not counted; start bit lasts 16 further ticks.
